// File: rtl/rv_fifo_lvl.sv
// ---------------------------------------------------------------------------
// rv_fifo_lvl
// Synchronous ready/valid FIFO with level flags and a high-water-mark monitor.
// Every storage entry is usable and any depth >= 2 works, including depths
// that are not powers of two, because pointer wrap uses an explicit compare.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   flush        synchronous clear of contents and count (hwm is kept)
//   hwm_clr      synchronous reload of the high-water mark with the next count
//   in_data      write payload
//   in_val       write request
//   in_rdy       FIFO can accept (registered, = !full)
//   out_data     head-of-queue payload (combinational read of registered state)
//   out_val      head valid (registered, = !empty)
//   out_rdy      consumer accepts
//   data_count   entries held, 0..FIFO_DEPTH
//   empty/full   count == 0 / count == FIFO_DEPTH
//   almost_empty count <= AEMPTY_LVL
//   almost_full  count >= AFULL_LVL
//   hwm          largest count seen since reset or the last hwm_clr
// ---------------------------------------------------------------------------
module rv_fifo_lvl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AFULL_LVL  = FIFO_DEPTH - 2,
  parameter int AEMPTY_LVL = 2,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  hwm_clr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_val,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [CW-1:0]         data_count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CW-1:0]         hwm
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AE_LVL   = CW'(AEMPTY_LVL);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [CW-1:0] hwm_q,    hwm_d;
  logic          empty_q,  empty_d;
  logic          full_q,   full_d;
  logic          aempty_q, aempty_d;
  logic          afull_q,  afull_d;

  logic in_xact;
  logic out_xact;

  // Wrap by compare rather than by overflow so non-power-of-2 depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == PTR_LAST) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  // Handshakes are qualified only by registered flags, never by the partner's strobe.
  always_comb begin
    in_xact  = in_val & ~full_q;
    out_xact = ~empty_q & out_rdy;
  end

  // Next-state for pointers, count, level flags and high-water mark.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Flush wins over any transfer presented in the same cycle.
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (in_xact) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (out_xact) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({in_xact, out_xact})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Flags are decoded from the next count and registered alongside it.
    empty_d  = (count_d == {CW{1'b0}});
    full_d   = (count_d == CNT_MAX);
    aempty_d = (count_d <= AE_LVL);
    afull_d  = (count_d >= AF_LVL);

    // With flush and hwm_clr together, count_d is zero so hwm clears.
    if (hwm_clr) begin
      hwm_d = count_d;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end else begin
      hwm_d = hwm_q;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      hwm_q    <= {CW{1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hwm_q    <= hwm_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
    end
  end

  // Storage write; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (in_xact && !flush) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Output drive from registered state.
  always_comb begin
    in_rdy       = ~full_q;
    out_val      = ~empty_q;
    out_data     = mem[rd_ptr_q];
    data_count   = count_q;
    empty        = empty_q;
    full         = full_q;
    almost_empty = aempty_q;
    almost_full  = afull_q;
    hwm          = hwm_q;
  end

endmodule
